// File: rtl/median3x3_stream_pkg.sv
// Shared constants and rank helpers for the 3x3 streaming rank filter.
// Helpers work on a wide unsigned word; callers zero-extend and truncate.
package median3x3_stream_pkg;

  localparam logic [1:0] MODE_MIN = 2'b00;
  localparam logic [1:0] MODE_MED = 2'b01;
  localparam logic [1:0] MODE_MAX = 2'b10;

  localparam int unsigned MedW = 32;

  function automatic logic [MedW-1:0] med3(input logic [MedW-1:0] a,
                                           input logic [MedW-1:0] b,
                                           input logic [MedW-1:0] c);
    logic [MedW-1:0] lo_ab;
    logic [MedW-1:0] hi_ab;
    lo_ab = (a < b) ? a : b;
    hi_ab = (a < b) ? b : a;
    if (c <= lo_ab) begin
      return lo_ab;
    end else if (c >= hi_ab) begin
      return hi_ab;
    end
    return c;
  endfunction

  function automatic logic [MedW-1:0] min3(input logic [MedW-1:0] a,
                                           input logic [MedW-1:0] b,
                                           input logic [MedW-1:0] c);
    logic [MedW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [MedW-1:0] max3(input logic [MedW-1:0] a,
                                           input logic [MedW-1:0] b,
                                           input logic [MedW-1:0] c);
    logic [MedW-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/sort3_cell.sv
// Combinational 3-input unsigned sorter producing hi, md and lo.
module sort3_cell #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] c_i,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] md_o,
  output logic [DATA_WIDTH-1:0] lo_o
);

  logic [DATA_WIDTH-1:0] ab_hi;
  logic [DATA_WIDTH-1:0] ab_lo;

  always_comb begin
    ab_hi = (a_i < b_i) ? b_i : a_i;
    ab_lo = (a_i < b_i) ? a_i : b_i;
    hi_o  = ab_hi;
    md_o  = c_i;
    lo_o  = ab_lo;
    if (c_i > ab_hi) begin
      hi_o = c_i;
      md_o = ab_hi;
    end else if (c_i < ab_lo) begin
      md_o = ab_lo;
      lo_o = c_i;
    end
  end

endmodule

// File: rtl/median3x3_stream.sv
// Streaming 3x3 min/median/max filter: sliding 3-column window per lane,
// followed by a two-register rank pipeline under one global stall.
module median3x3_stream
  import median3x3_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CHANNELS   = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [1:0]                         mode,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_sol,
  input  logic [CHANNELS*3*DATA_WIDTH-1:0]   in_col,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_sol,
  output logic [CHANNELS*DATA_WIDTH-1:0]     out_pix
);

  localparam int unsigned DW = DATA_WIDTH;

  logic       en;
  logic       accept;
  logic [1:0] cnt_q, cnt_d;
  logic       win_v_q, win_v_d;
  logic       win_sol_q, win_sol_d;
  logic [1:0] mode0_q, mode0_d;
  logic       v1_q, v1_d;
  logic       sol1_q, sol1_d;
  logic [1:0] mode1_q, mode1_d;
  logic       out_valid_q, out_valid_d;
  logic       out_sol_q, out_sol_d;

  assign en        = !out_valid_q || out_ready;
  assign accept    = en && in_valid;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_sol   = out_sol_q;

  // win_v marks a freshly completed window waiting to enter stage 1.
  always_comb begin
    cnt_d       = cnt_q;
    win_v_d     = win_v_q;
    win_sol_d   = win_sol_q;
    mode0_d     = mode0_q;
    v1_d        = v1_q;
    sol1_d      = sol1_q;
    mode1_d     = mode1_q;
    out_valid_d = out_valid_q;
    out_sol_d   = out_sol_q;
    if (accept) begin
      if (in_sol) begin
        cnt_d = 2'd1;
      end else if (cnt_q != 2'd3) begin
        cnt_d = cnt_q + 2'd1;
      end
      win_v_d   = (cnt_d == 2'd3);
      win_sol_d = !in_sol && (cnt_q == 2'd2);
      mode0_d   = mode;
    end else if (en) begin
      win_v_d = 1'b0;
    end
    if (en) begin
      v1_d   = win_v_q;
      sol1_d = win_v_q && win_sol_q;
      if (win_v_q) begin
        mode1_d = mode0_q;
      end
      out_valid_d = v1_q;
      out_sol_d   = v1_q && sol1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      win_v_q     <= 1'b0;
      win_sol_q   <= 1'b0;
      mode0_q     <= '0;
      v1_q        <= 1'b0;
      sol1_q      <= 1'b0;
      mode1_q     <= '0;
      out_valid_q <= 1'b0;
      out_sol_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      win_v_q     <= win_v_d;
      win_sol_q   <= win_sol_d;
      mode0_q     <= mode0_d;
      v1_q        <= v1_d;
      sol1_q      <= sol1_d;
      mode1_q     <= mode1_d;
      out_valid_q <= out_valid_d;
      out_sol_q   <= out_sol_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    logic [DW-1:0] col_top, col_mid, col_bot;
    logic [DW-1:0] s_hi, s_md, s_lo;
    logic [DW-1:0] hi_q[3], hi_d[3];
    logic [DW-1:0] md_q[3], md_d[3];
    logic [DW-1:0] lo_q[3], lo_d[3];
    logic [DW-1:0] mx_lo_q, mx_lo_d;
    logic [DW-1:0] md_md_q, md_md_d;
    logic [DW-1:0] mn_hi_q, mn_hi_d;
    logic [DW-1:0] gmin_q, gmin_d;
    logic [DW-1:0] gmax_q, gmax_d;
    logic [DW-1:0] pix_q, pix_d;

    assign col_top = in_col[g*3*DW + 2*DW +: DW];
    assign col_mid = in_col[g*3*DW + DW +: DW];
    assign col_bot = in_col[g*3*DW +: DW];

    sort3_cell #(
      .DATA_WIDTH(DW)
    ) u_sort (
      .a_i (col_top),
      .b_i (col_mid),
      .c_i (col_bot),
      .hi_o(s_hi),
      .md_o(s_md),
      .lo_o(s_lo)
    );

    // Median of 9 = med(max of column mins, med of medians, min of column maxes).
    always_comb begin
      hi_d    = hi_q;
      md_d    = md_q;
      lo_d    = lo_q;
      mx_lo_d = mx_lo_q;
      md_md_d = md_md_q;
      mn_hi_d = mn_hi_q;
      gmin_d  = gmin_q;
      gmax_d  = gmax_q;
      pix_d   = pix_q;
      if (accept) begin
        hi_d[0] = s_hi;
        hi_d[1] = hi_q[0];
        hi_d[2] = hi_q[1];
        md_d[0] = s_md;
        md_d[1] = md_q[0];
        md_d[2] = md_q[1];
        lo_d[0] = s_lo;
        lo_d[1] = lo_q[0];
        lo_d[2] = lo_q[1];
      end
      if (en && win_v_q) begin
        mx_lo_d = DW'(max3(MedW'(lo_q[0]), MedW'(lo_q[1]), MedW'(lo_q[2])));
        md_md_d = DW'(med3(MedW'(md_q[0]), MedW'(md_q[1]), MedW'(md_q[2])));
        mn_hi_d = DW'(min3(MedW'(hi_q[0]), MedW'(hi_q[1]), MedW'(hi_q[2])));
        gmin_d  = DW'(min3(MedW'(lo_q[0]), MedW'(lo_q[1]), MedW'(lo_q[2])));
        gmax_d  = DW'(max3(MedW'(hi_q[0]), MedW'(hi_q[1]), MedW'(hi_q[2])));
      end
      if (en && v1_q) begin
        case (mode1_q)
          MODE_MIN: pix_d = gmin_q;
          MODE_MAX: pix_d = gmax_q;
          default:  pix_d = DW'(med3(MedW'(mx_lo_q), MedW'(md_md_q), MedW'(mn_hi_q)));
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hi_q    <= '{default: '0};
        md_q    <= '{default: '0};
        lo_q    <= '{default: '0};
        mx_lo_q <= '0;
        md_md_q <= '0;
        mn_hi_q <= '0;
        gmin_q  <= '0;
        gmax_q  <= '0;
        pix_q   <= '0;
      end else begin
        hi_q    <= hi_d;
        md_q    <= md_d;
        lo_q    <= lo_d;
        mx_lo_q <= mx_lo_d;
        md_md_q <= md_md_d;
        mn_hi_q <= mn_hi_d;
        gmin_q  <= gmin_d;
        gmax_q  <= gmax_d;
        pix_q   <= pix_d;
      end
    end

    assign out_pix[g*DW +: DW] = pix_q;
  end

endmodule

// File: tb/tb_median3x3_stream.sv
// Scoreboard bench for median3x3_stream: driver pushes expectations from a
// brute-force 9-value sort, a separate monitor pops on every output handshake.
module tb_median3x3_stream;

  localparam int DW = 8;
  localparam int CH = 3;
  localparam int CW = CH * 3 * DW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      mode = 2'b01;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_sol = 1'b0;
  logic [CW-1:0]   in_col = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_sol;
  logic [CH*DW-1:0] out_pix;

  median3x3_stream #(
    .DATA_WIDTH(DW),
    .CHANNELS  (CH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sol   (in_sol),
    .in_col   (in_col),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sol  (out_sol),
    .out_pix  (out_pix)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             sol;
    logic [CH*DW-1:0] pix;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int n_out = 0;

  logic [DW-1:0] mw[CH][3][3];  // lane, slot (0 newest), row (0 top)
  int mcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rank(input int l, input logic [1:0] md);
    int a[9];
    int t;
    for (int s = 0; s < 3; s++)
      for (int r = 0; r < 3; r++) a[s*3+r] = int'(mw[l][s][r]);
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    if (md == 2'b00) return DW'(a[0]);
    if (md == 2'b10) return DW'(a[8]);
    return DW'(a[4]);
  endfunction

  function automatic logic [CW-1:0] col3(input logic [DW-1:0] t, input logic [DW-1:0] m,
                                         input logic [DW-1:0] b);
    logic [CW-1:0] r;
    for (int l = 0; l < CH; l++) r[l*3*DW +: 3*DW] = {t, m, b};
    return r;
  endfunction

  function automatic logic [CW-1:0] pat(input int c);
    logic [CW-1:0] r;
    for (int l = 0; l < CH; l++)
      for (int k = 0; k < 3; k++) r[l*3*DW + (2-k)*DW +: DW] = DW'((c*37 + k*91 + l*53 + 11) % 256);
    return r;
  endfunction

  function automatic logic [CW-1:0] pat_ff(input int c);
    logic [CW-1:0] r;
    r[0 +: 3*DW] = {3{8'hFF}};
    r[3*DW +: 3*DW] = {3{8'h00}};
    r[6*DW +: 3*DW] = (c % 2 == 0) ? {8'hFF, 8'h00, 8'hFF} : {8'h00, 8'hFF, 8'h00};
    return r;
  endfunction

  task automatic send(input logic sol, input logic [1:0] md, input logic [CW-1:0] col);
    int guard;
    int prev;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_sol = sol;
    mode = md;
    in_col = col;
    #1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck at 0 expected 1");
    end
    @(posedge clk);
    prev = mcnt;
    mcnt = sol ? 1 : ((mcnt == 3) ? 3 : mcnt + 1);
    for (int l = 0; l < CH; l++) begin
      mw[l][2] = mw[l][1];
      mw[l][1] = mw[l][0];
      for (int r = 0; r < 3; r++) mw[l][0][r] = col[l*3*DW + (2-r)*DW +: DW];
    end
    if (mcnt == 3) begin
      e.sol = (prev == 2) && !sol;
      for (int l = 0; l < CH; l++) e.pix[l*DW +: DW] = rank(l, md);
      q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_sol = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Hand-computed line: window holds 1..9; checks latency and lane 0 value.
  task automatic line_hand(input logic [1:0] md, input logic [DW-1:0] exp_pix);
    send(1'b1, md, col3(8'd9, 8'd1, 8'd5));
    send(1'b0, md, col3(8'd2, 8'd8, 8'd3));
    send(1'b0, md, col3(8'd7, 8'd4, 8'd6));
    @(negedge clk);
    in_valid = 1'b0;
    in_sol = 1'b0;
    #1 chk("lat_edge1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1 chk("lat_edge2_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1 chk("lat_edge3_valid", 64'(out_valid), 64'd1);
    chk("hand_pix", 64'(out_pix[DW-1:0]), 64'(exp_pix));
    chk("hand_sol", 64'(out_sol), 64'd1);
    drain();
  endtask

  // Monitor: samples 1ns before each rising edge, i.e. what the DUT sees.
  logic stall_prev = 1'b0;
  logic [CH*DW-1:0] prev_pix;
  logic prev_sol;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (out_valid) chk("in_ready_stall", 64'(in_ready), 64'(out_ready));
        if (stall_prev) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_pix", 64'(out_pix), 64'(prev_pix));
          chk("hold_sol", 64'(out_sol), 64'(prev_sol));
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got pix %0h expected none", out_pix);
          end else begin
            e = q.pop_front();
            chk("out_sol", 64'(out_sol), 64'(e.sol));
            chk("out_pix", 64'(out_pix), 64'(e.pix));
          end
        end
        stall_prev = out_valid && !out_ready;
        prev_pix = out_pix;
        prev_sol = out_sol;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pix", 64'(out_pix), 64'd0);
    chk("rst_out_sol", 64'(out_sol), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    #2 rst_n = 1'b1;

    // Hand-computed median / min / max.
    line_hand(2'b01, 8'd5);
    line_hand(2'b00, 8'd1);
    line_hand(2'b10, 8'd9);

    // 10-column streaming line.
    n0 = n_out;
    for (int c = 0; c < 10; c++) send(c == 0, 2'b01, pat(c));
    idle();
    drain();
    chk("stream_count", 64'(n_out - n0), 64'd8);

    // Backpressure mid-line with per-column mode changes.
    n0 = n_out;
    fork
      begin
        for (int c = 0; c < 10; c++) send(c == 0, 2'(c % 4), pat(c + 20));
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(n_out - n0), 64'd8);

    // in_sol after two columns restarts priming.
    n0 = n_out;
    send(1'b1, 2'b01, pat(40));
    send(1'b0, 2'b01, pat(41));
    send(1'b1, 2'b01, pat(42));
    send(1'b0, 2'b01, pat(43));
    idle();
    repeat (4) @(negedge clk);
    chk("resol_no_result", 64'(n_out - n0), 64'd0);
    send(1'b0, 2'b01, pat(44));
    idle();
    drain();
    chk("resol_count", 64'(n_out - n0), 64'd1);

    // All-equal saturated lanes with random mode per column.
    n0 = n_out;
    for (int c = 0; c < 8; c++) send(c == 0, 2'($urandom_range(0, 3)), pat_ff(c));
    idle();
    drain();
    chk("ties_count", 64'(n_out - n0), 64'd6);

    // Reset mid-stream with results in flight.
    send(1'b1, 2'b01, pat(60));
    send(1'b0, 2'b01, pat(61));
    send(1'b0, 2'b01, pat(62));
    send(1'b0, 2'b01, pat(63));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_pix", 64'(out_pix), 64'd0);
    chk("midrst_out_sol", 64'(out_sol), 64'd0);
    q.delete();
    mcnt = 0;
    in_valid = 1'b0;
    in_sol = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("midrst_in_ready", 64'(in_ready), 64'd1);
    n0 = n_out;
    repeat (4) @(negedge clk);
    chk("midrst_no_output", 64'(n_out - n0), 64'd0);
    for (int c = 0; c < 4; c++) send(c == 0, 2'b01, pat(70 + c));
    idle();
    drain();
    chk("midrst_recover", 64'(n_out - n0), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
